// File: rtl/rtc_pkg.sv
// Shared types, field widths, limits and word-packing helpers for the RTC host.
package rtc_pkg;

    typedef enum logic [1:0] {
        RTC_OP_READ   = 2'd0,
        RTC_OP_WRITE  = 2'd1,
        RTC_OP_ALARM  = 2'd2,
        RTC_OP_ADDSUB = 2'd3
    } rtc_op_e;

    typedef enum logic [2:0] {
        CMD_READ      = 3'd0,
        CMD_WRITE     = 3'd1,
        CMD_ALARM     = 3'd2,
        CMD_ADD       = 3'd3,
        CMD_SUB       = 3'd4,
        CMD_RTC_RESET = 3'd5
    } host_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RST,
        ST_RESP
    } host_state_e;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;
    localparam int DAY_W = 9;
    localparam int YR_W  = 6;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
    localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
    localparam logic [DAY_W-1:0] DAY_MAX = 9'd364;

    // RTC word layout: sec[31:26] min[25:20] hr[19:15] day[14:6] yr[5:0]
    function automatic logic [31:0] pack_write(input logic [SEC_W-1:0] sec,
                                               input logic [MIN_W-1:0] min,
                                               input logic [HR_W-1:0]  hr,
                                               input logic [DAY_W-1:0] day,
                                               input logic [YR_W-1:0]  yr);
        return {sec, min, hr, day, yr};
    endfunction

    function automatic logic [31:0] pack_alarm(input logic [SEC_W-1:0] sec,
                                               input logic [MIN_W-1:0] min,
                                               input logic [HR_W-1:0]  hr);
        return {sec, min, hr, 1'b1, 14'b0};
    endfunction

    function automatic logic [31:0] pack_addsub(input logic [SEC_W-1:0] sec,
                                                input logic [MIN_W-1:0] min,
                                                input logic [HR_W-1:0]  hr,
                                                input logic [DAY_W-1:0] day,
                                                input logic             add);
        return {sec, min, hr, day, add, 5'b0};
    endfunction

endpackage

// File: rtl/rtc_cmd_pack.sv
// Combinational command decode: range check of the fields an op uses and
// packing into the RTC operation code and 32-bit write word.
module rtc_cmd_pack
    import rtc_pkg::*;
(
    input  logic [2:0]       op,
    input  logic [SEC_W-1:0] sec,
    input  logic [MIN_W-1:0] min,
    input  logic [HR_W-1:0]  hr,
    input  logic [DAY_W-1:0] day,
    input  logic [YR_W-1:0]  yr,
    output logic             err,
    output logic [1:0]       rtc_op,
    output logic [31:0]      word
);

    logic time_bad;
    logic day_bad;

    assign time_bad = (sec > SEC_MAX) || (min > MIN_MAX) || (hr > HR_MAX);
    assign day_bad  = (day > DAY_MAX);

    always_comb begin
        err    = 1'b0;
        rtc_op = RTC_OP_READ;
        word   = '0;
        case (op)
            CMD_READ: begin
                rtc_op = RTC_OP_READ;
            end
            CMD_WRITE: begin
                err    = time_bad || day_bad;
                rtc_op = RTC_OP_WRITE;
                word   = pack_write(sec, min, hr, day, yr);
            end
            CMD_ALARM: begin
                err    = time_bad;
                rtc_op = RTC_OP_ALARM;
                word   = pack_alarm(sec, min, hr);
            end
            CMD_ADD: begin
                err    = time_bad || day_bad;
                rtc_op = RTC_OP_ADDSUB;
                word   = pack_addsub(sec, min, hr, day, 1'b1);
            end
            CMD_SUB: begin
                err    = time_bad || day_bad;
                rtc_op = RTC_OP_ADDSUB;
                word   = pack_addsub(sec, min, hr, day, 1'b0);
            end
            CMD_RTC_RESET: begin
                rtc_op = RTC_OP_READ;
            end
            default: begin
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rtc_host.sv
// RTC command initiator: one outstanding command, RTC handshake, response strobe
// and alarm interrupt. Define RTC_HOST_ALARM_LATCH_EN for a sticky, clearable irq.
module rtc_host
    import rtc_pkg::*;
#(
    parameter int RST_CYCLES = 2,
    parameter int READ_LAT   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [SEC_W-1:0] cmd_sec,
    input  logic [MIN_W-1:0] cmd_min,
    input  logic [HR_W-1:0]  cmd_hr,
    input  logic [DAY_W-1:0] cmd_day,
    input  logic [YR_W-1:0]  cmd_yr,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [31:0]      rsp_data,
    output logic             rtc_on,
    output logic             rtc_resetn,
    output logic [1:0]       rtc_operation,
    output logic [31:0]      rtc_w_data,
    input  logic [31:0]      rtc_r_data,
    input  logic             rtc_alarm,
    output logic             alarm_irq,
    input  logic             irq_clr
);

    localparam int CNT_W = 16;

    host_state_e      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;

    logic             pack_err;
    logic [1:0]       pack_op;
    logic [31:0]      pack_word;
    logic             accept;

    logic             rtc_on_reg, rtc_on_next;
    logic             rtc_resetn_reg, rtc_resetn_next;
    logic [1:0]       rtc_operation_reg, rtc_operation_next;
    logic [31:0]      rtc_w_data_reg, rtc_w_data_next;
    logic             rsp_valid_reg, rsp_valid_next;
    logic             rsp_err_reg, rsp_err_next;
    logic [31:0]      rsp_data_reg, rsp_data_next;
    logic             alarm_irq_reg;

    rtc_cmd_pack u_pack (
        .op     (cmd_op),
        .sec    (cmd_sec),
        .min    (cmd_min),
        .hr     (cmd_hr),
        .day    (cmd_day),
        .yr     (cmd_yr),
        .err    (pack_err),
        .rtc_op (pack_op),
        .word   (pack_word)
    );

    assign cmd_ready = (state_reg == ST_IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (pack_err)                     state_next = ST_RESP;
                    else if (cmd_op == CMD_RTC_RESET) state_next = ST_RST;
                    else                              state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = (rtc_operation_reg == RTC_OP_READ) ? ST_WAIT : ST_RESP;
            ST_WAIT:  state_next = (cnt_reg == '0) ? ST_RESP : ST_WAIT;
            ST_RST:   state_next = (cnt_reg == '0) ? ST_RESP : ST_RST;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Loaded on entry to WAIT/RST so each lasts exactly its configured cycle count
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (state_next == ST_WAIT && state_reg != ST_WAIT) begin
            cnt_reg <= CNT_W'(READ_LAT - 1);
        end else if (state_next == ST_RST && state_reg != ST_RST) begin
            cnt_reg <= CNT_W'(RST_CYCLES - 1);
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    always_comb begin
        rtc_on_next        = (state_next == ST_ISSUE);
        rtc_resetn_next    = (state_next != ST_RST);
        rtc_operation_next = rtc_operation_reg;
        rtc_w_data_next    = rtc_w_data_reg;
        if (state_reg == ST_IDLE && state_next == ST_ISSUE) begin
            rtc_operation_next = pack_op;
            rtc_w_data_next    = pack_word;
        end
        rsp_valid_next = (state_next == ST_RESP);
        rsp_err_next   = (state_reg == ST_IDLE) && (state_next == ST_RESP);
        rsp_data_next  = '0;
        if (state_reg == ST_WAIT && state_next == ST_RESP) begin
            rsp_data_next = rtc_r_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rtc_on_reg        <= 1'b0;
            rtc_resetn_reg    <= 1'b0;
            rtc_operation_reg <= '0;
            rtc_w_data_reg    <= '0;
            rsp_valid_reg     <= 1'b0;
            rsp_err_reg       <= 1'b0;
            rsp_data_reg      <= '0;
        end else begin
            rtc_on_reg        <= rtc_on_next;
            rtc_resetn_reg    <= rtc_resetn_next;
            rtc_operation_reg <= rtc_operation_next;
            rtc_w_data_reg    <= rtc_w_data_next;
            rsp_valid_reg     <= rsp_valid_next;
            rsp_err_reg       <= rsp_err_next;
            rsp_data_reg      <= rsp_data_next;
        end
    end

`ifdef RTC_HOST_ALARM_LATCH_EN
    logic alarm_prev_reg;

    // A fresh rising edge beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_prev_reg <= 1'b0;
            alarm_irq_reg  <= 1'b0;
        end else begin
            alarm_prev_reg <= rtc_alarm;
            if (rtc_alarm && !alarm_prev_reg) begin
                alarm_irq_reg <= 1'b1;
            end else if (irq_clr) begin
                alarm_irq_reg <= 1'b0;
            end
        end
    end
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr;

    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_irq_reg <= 1'b0;
        end else begin
            alarm_irq_reg <= rtc_alarm;
        end
    end
`endif

    assign rtc_on        = rtc_on_reg;
    assign rtc_resetn    = rtc_resetn_reg;
    assign rtc_operation = rtc_operation_reg;
    assign rtc_w_data    = rtc_w_data_reg;
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_err       = rsp_err_reg;
    assign rsp_data      = rsp_data_reg;
    assign alarm_irq     = alarm_irq_reg;

endmodule

// File: tb/tb_rtc_host.sv
// Self-checking bench for rtc_host: directed and random commands against a
// cycle-level reference of the command timeline, plus alarm interrupt checks.
module tb_rtc_host;

    localparam int RST_CYCLES = 2;
    localparam int READ_LAT   = 1;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [5:0]  cmd_sec;
    logic [5:0]  cmd_min;
    logic [4:0]  cmd_hr;
    logic [8:0]  cmd_day;
    logic [5:0]  cmd_yr;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_data;
    logic        rtc_on;
    logic        rtc_resetn;
    logic [1:0]  rtc_operation;
    logic [31:0] rtc_w_data;
    logic [31:0] rtc_r_data;
    logic        rtc_alarm;
    logic        alarm_irq;
    logic        irq_clr;

    int errors = 0;
    int checks = 0;

    logic [31:0] last_w;
    logic [1:0]  last_op;
    logic        exp_irq;
    logic        prev_alarm;

    rtc_host #(.RST_CYCLES(RST_CYCLES), .READ_LAT(READ_LAT)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_sec       (cmd_sec),
        .cmd_min       (cmd_min),
        .cmd_hr        (cmd_hr),
        .cmd_day       (cmd_day),
        .cmd_yr        (cmd_yr),
        .rsp_valid     (rsp_valid),
        .rsp_err       (rsp_err),
        .rsp_data      (rsp_data),
        .rtc_on        (rtc_on),
        .rtc_resetn    (rtc_resetn),
        .rtc_operation (rtc_operation),
        .rtc_w_data    (rtc_w_data),
        .rtc_r_data    (rtc_r_data),
        .rtc_alarm     (rtc_alarm),
        .alarm_irq     (alarm_irq),
        .irq_clr       (irq_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: which commands are rejected
    function automatic bit model_err(int op, int s, int m, int h, int d);
        if (op >= 6) return 1'b1;
        if (op == 0 || op == 5) return 1'b0;
        if (s > 59 || m > 59 || h > 23) return 1'b1;
        if (op != 2 && d > 364) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: RTC word by positional arithmetic on the field values
    function automatic logic [31:0] model_word(int op, int s, int m, int h, int d, int y);
        longint base;
        base = longint'(s) * 64'd67108864 + longint'(m) * 64'd1048576 + longint'(h) * 64'd32768;
        case (op)
            1:       return 32'(base + longint'(d) * 64 + y);
            2:       return 32'(base + 64'd16384);
            3:       return 32'(base + longint'(d) * 64 + 32);
            4:       return 32'(base + longint'(d) * 64);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [1:0] model_op(int op);
        if (op == 3 || op == 4) return 2'd3;
        return 2'(op);
    endfunction

    task automatic run_cmd(input int op, input int s, input int m, input int h, input int d, input int y);
        int          on_cnt, on_cyc, rl_cnt, rl_first, rsp_cyc;
        int          exp_rsp, exp_on, exp_rl;
        logic [1:0]  op_seen;
        logic [31:0] w_seen, data_seen, base, exp_data;
        logic        err_seen, exp_err;
        on_cnt = 0; on_cyc = -1; rl_cnt = 0; rl_first = -1; rsp_cyc = -1;
        op_seen = '0; w_seen = '0; data_seen = '0; err_seen = 1'b0;
        base = $urandom();

        @(negedge clk);
        check("cmd_ready_before", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op = 3'(op); cmd_sec = 6'(s); cmd_min = 6'(m);
        cmd_hr = 5'(h); cmd_day = 9'(d); cmd_yr = 6'(y);
        rtc_r_data = base;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom); cmd_sec = 6'($urandom); cmd_min = 6'($urandom);
        cmd_hr = 5'($urandom); cmd_day = 9'($urandom); cmd_yr = 6'($urandom);

        for (int k = 0; k < 40 && rsp_cyc < 0; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (rtc_on === 1'b1) begin
                on_cnt++; on_cyc = k; op_seen = rtc_operation; w_seen = rtc_w_data;
            end
            if (rtc_resetn !== 1'b1) begin
                if (rl_cnt == 0) rl_first = k;
                rl_cnt++;
            end
            if (rsp_valid === 1'b1) begin
                rsp_cyc = k; err_seen = rsp_err; data_seen = rsp_data;
            end else begin
                check("rsp_idle_zero", {31'b0, rsp_err} | rsp_data, 32'd0);
            end
            rtc_r_data = base + 32'(k);
        end
        if (rsp_cyc < 0) check("rsp_timeout", 32'd0, 32'd1);

        exp_err  = model_err(op, s, m, h, d);
        exp_data = 32'd0;
        exp_on   = 0;
        exp_rl   = 0;
        if (exp_err) begin
            exp_rsp = 0;
        end else if (op == 5) begin
            exp_rsp = RST_CYCLES;
            exp_rl  = RST_CYCLES;
        end else begin
            exp_on  = 1;
            exp_rsp = (op == 0) ? 1 + READ_LAT : 1;
            if (op == 0) exp_data = base + 32'(READ_LAT);
        end

        check("rsp_cycle", 32'(rsp_cyc), 32'(exp_rsp));
        check("rsp_err", {31'b0, err_seen}, {31'b0, exp_err});
        check("rsp_data", data_seen, exp_data);
        check("rtc_on_count", 32'(on_cnt), 32'(exp_on));
        check("resetn_low_count", 32'(rl_cnt), 32'(exp_rl));
        if (exp_on == 1) begin
            check("rtc_on_cycle", 32'(on_cyc), 32'd0);
            check("rtc_operation", {30'b0, op_seen}, {30'b0, model_op(op)});
            check("rtc_w_data", w_seen, model_word(op, s, m, h, d, y));
            last_op = model_op(op);
            last_w  = model_word(op, s, m, h, d, y);
        end
        if (exp_rl > 0) check("resetn_low_start", 32'(rl_first), 32'd0);

        @(posedge clk);
        #1;
        check("rsp_valid_drop", {31'b0, rsp_valid}, 32'd0);
        check("cmd_ready_after", {31'b0, cmd_ready}, 32'd1);
        check("w_data_hold", rtc_w_data, last_w);
        check("op_hold", {30'b0, rtc_operation}, {30'b0, last_op});
        $display("txn op=%0d sec=%0d min=%0d hr=%0d day=%0d yr=%0d err=%0d rsp_cycle=%0d data=%h",
                 op, s, m, h, d, y, err_seen, rsp_cyc, data_seen);
    endtask

    task automatic alarm_step(input logic a, input logic c);
        @(negedge clk);
        rtc_alarm = a;
        irq_clr   = c;
        @(posedge clk);
`ifdef RTC_HOST_ALARM_LATCH_EN
        if (a && !prev_alarm) exp_irq = 1'b1;
        else if (c)           exp_irq = 1'b0;
`else
        exp_irq = a;
`endif
        prev_alarm = a;
        #1;
        check("alarm_irq", {31'b0, alarm_irq}, {31'b0, exp_irq});
        $display("alarm step alarm=%0d clr=%0d irq=%0d", a, c, alarm_irq);
    endtask

    initial begin
        int rsp_seen;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_sec = '0; cmd_min = '0;
        cmd_hr = '0; cmd_day = '0; cmd_yr = '0; rtc_r_data = '0; rtc_alarm = 1'b0; irq_clr = 1'b0;
        last_w = '0; last_op = '0; exp_irq = 1'b0; prev_alarm = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_rtc_on", {31'b0, rtc_on}, 32'd0);
        check("reset_rtc_resetn", {31'b0, rtc_resetn}, 32'd0);
        check("reset_rtc_operation", {30'b0, rtc_operation}, 32'd0);
        check("reset_rtc_w_data", rtc_w_data, 32'd0);
        check("reset_rsp", {30'b0, rsp_valid, rsp_err} | rsp_data, 32'd0);
        check("reset_alarm_irq", {31'b0, alarm_irq}, 32'd0);
        check("reset_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("resetn_release", {31'b0, rtc_resetn}, 32'd1);
        $display("reset released");

        // Directed commands, including field-limit boundaries
        run_cmd(1, 1, 1, 1, 1, 1);
        run_cmd(0, 0, 0, 0, 0, 0);
        run_cmd(3, 59, 59, 23, 364, 0);
        run_cmd(4, 2, 2, 2, 2, 0);
        run_cmd(1, 60, 0, 0, 0, 0);
        run_cmd(7, 1, 1, 1, 1, 1);
        run_cmd(6, 0, 0, 0, 0, 0);
        run_cmd(5, 63, 63, 31, 511, 63);
        run_cmd(1, 59, 59, 23, 364, 63);
        run_cmd(3, 10, 10, 10, 365, 0);
        run_cmd(2, 30, 15, 12, 511, 0);
        run_cmd(2, 30, 15, 24, 0, 0);
        run_cmd(4, 0, 60, 0, 0, 0);
        run_cmd(0, 63, 63, 31, 511, 63);

        // Random commands
        for (int i = 0; i < 40; i++) begin
            run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 511)), int'($urandom_range(0, 63)));
        end

        // Reset while a read is waiting for data
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("midreset_resetn", {31'b0, rtc_resetn}, 32'd0);
        check("midreset_w_data", rtc_w_data, 32'd0);
        check("midreset_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        last_w = '0; last_op = '0;
        @(negedge clk);
        reset = 1'b0;
        rsp_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid === 1'b1) rsp_seen++;
        end
        check("midreset_no_rsp", 32'(rsp_seen), 32'd0);
        check("midreset_ready_back", {31'b0, cmd_ready}, 32'd1);
        check("midreset_resetn_back", {31'b0, rtc_resetn}, 32'd1);
        $display("mid-command reset done rsp_seen=%0d", rsp_seen);
        run_cmd(1, 5, 6, 7, 8, 9);

        // Alarm: rise and hold with clears, then random activity
        alarm_step(1'b0, 1'b0);
        alarm_step(1'b1, 1'b0);
        alarm_step(1'b1, 1'b0);
        alarm_step(1'b1, 1'b1);
        alarm_step(1'b1, 1'b0);
        alarm_step(1'b1, 1'b1);
        alarm_step(1'b1, 1'b0);
        alarm_step(1'b0, 1'b0);
        alarm_step(1'b0, 1'b1);
        for (int i = 0; i < 24; i++) begin
            alarm_step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end
        alarm_step(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
